victim_way_select: RTL and testbench

VICTIM_WAY_SELECT -- requirements
Module: victim_way_select

---
 rtl/victim_way_select_pkg.sv | 17 +
 rtl/way_decoder.sv | 25 ++
 rtl/victim_way_select.sv | 143 ++++++++++++++
 tb/tb_victim_way_select.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/victim_way_select_pkg.sv
// Shared cache definitions for the victim way selector.
//
// Contents:
//   NUM_WAYS_DEFAULT  default associativity (power of two, >= 2)
//   NUM_SETS_DEFAULT  default number of sets (power of two)
//   vws_state_e       handshake FSM state type
package victim_way_select_pkg;

  localparam int unsigned NUM_WAYS_DEFAULT = 4;
  localparam int unsigned NUM_SETS_DEFAULT = 16;

  typedef enum logic [0:0] {
    StIdle,
    StResp
  } vws_state_e;

endpackage

// File: rtl/way_decoder.sv
// Binary way index to one-hot way write-enable decoder.
//
// Ports:
//   idx  in  WAY_W     binary way index
//   oh   out NUM_WAYS  one-hot decode of idx (bit idx set)
module way_decoder
  import victim_way_select_pkg::*;
#(
  parameter int unsigned NUM_WAYS = NUM_WAYS_DEFAULT,
  parameter int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [WAY_W-1:0]    idx,
  output logic [NUM_WAYS-1:0] oh
);

  always_comb begin
    oh = '0;
    for (int i = 0; i < int'(NUM_WAYS); i++) begin
      if (idx == WAY_W'(i)) begin
        oh[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/victim_way_select.sv
// Victim way selector for a set-associative cache.
//
// On an accepted request the victim is the lowest-index invalid way of the
// set; if the set is full, the set's round-robin pointer picks the victim and
// advances when the response is consumed. One request per two cycles.
//
// Ports:
//   clk             in   1         clock, rising edge
//   rst_n           in   1         asynchronous active-low reset
//   req_valid       in   1         victim request present
//   req_ready       out  1         high while idle
//   req_set         in   SET_W     set index of the miss
//   req_line_valid  in   NUM_WAYS  per-way valid bits of that set
//   rsp_valid       out  1         victim result present
//   rsp_ready       in   1         consumer accepts the result
//   rsp_way_idx     out  WAY_W     binary victim way
//   rsp_way_oh      out  NUM_WAYS  one-hot victim way write-enable
//   rsp_by_rr       out  1         1 = round-robin pick, 0 = invalid way
//   flush           in   1         synchronous clear of all pointers
module victim_way_select
  import victim_way_select_pkg::*;
#(
  parameter int unsigned NUM_WAYS = NUM_WAYS_DEFAULT,
  parameter int unsigned NUM_SETS = NUM_SETS_DEFAULT,
  parameter int unsigned WAY_W    = $clog2(NUM_WAYS),
  parameter int unsigned SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_W-1:0]    req_set,
  input  logic [NUM_WAYS-1:0] req_line_valid,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WAY_W-1:0]    rsp_way_idx,
  output logic [NUM_WAYS-1:0] rsp_way_oh,
  output logic                rsp_by_rr,
  input  logic                flush
);

  vws_state_e state_q, state_d;

  logic [WAY_W-1:0] ptr_q [NUM_SETS];
  logic [WAY_W-1:0] ptr_d [NUM_SETS];

  logic [WAY_W-1:0] way_idx_q, way_idx_d;
  logic             by_rr_q, by_rr_d;
  logic [SET_W-1:0] set_q, set_d;

  logic             req_fire;
  logic             rsp_fire;
  logic             inv_found;
  logic [WAY_W-1:0] inv_idx;

  assign req_fire = (state_q == StIdle) && req_valid;
  assign rsp_fire = (state_q == StResp) && rsp_ready;

  // Lowest-index invalid way: scan downwards so the last hit is the lowest.
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (!req_line_valid[i]) begin
        inv_found = 1'b1;
        inv_idx   = WAY_W'(i);
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Response capture: inputs are only looked at on acceptance.
  always_comb begin
    way_idx_d = way_idx_q;
    by_rr_d   = by_rr_q;
    set_d     = set_q;
    if (req_fire) begin
      way_idx_d = inv_found ? inv_idx : ptr_q[req_set];
      by_rr_d   = ~inv_found;
      set_d     = req_set;
    end
  end

  // Pointer update; flush overrides an advance in the same cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (rsp_fire && by_rr_q) begin
      ptr_d[set_q] = ptr_q[set_q] + WAY_W'(1);
    end
    if (flush) begin
      ptr_d = '{default: '0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      way_idx_q <= '0;
      by_rr_q   <= 1'b0;
      set_q     <= '0;
      ptr_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      way_idx_q <= way_idx_d;
      by_rr_q   <= by_rr_d;
      set_q     <= set_d;
      ptr_q     <= ptr_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_way_idx = way_idx_q;
  assign rsp_by_rr   = by_rr_q;

  way_decoder #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_way_decoder (
    .idx (way_idx_q),
    .oh  (rsp_way_oh)
  );

`ifndef SYNTHESIS
  a_oh_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot(rsp_way_oh));

  a_rsp_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_way_idx) && $stable(rsp_by_rr)));

  a_ready_excl : assert property (@(posedge clk) disable iff (!rst_n)
    (req_ready != rsp_valid));
`endif

endmodule

// File: tb/tb_victim_way_select.sv
module tb_victim_way_select;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_set = '0;
  logic [3:0] req_line_valid = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [1:0] rsp_way_idx;
  logic [3:0] rsp_way_oh;
  logic       rsp_by_rr;
  logic       flush = 1'b0;

  localparam logic [3:0] Full = 4'b1111;

  typedef struct packed {
    logic [1:0] idx;
    logic       rr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;
  int issued = 0;
  int hs_count = 0;

  victim_way_select dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_set        (req_set),
    .req_line_valid (req_line_valid),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_way_idx    (rsp_way_idx),
    .rsp_way_oh     (rsp_way_oh),
    .rsp_by_rr      (rsp_by_rr),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every consumed response against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=idx%0d required=no_response", rsp_way_idx);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_way_idx", 32'(rsp_way_idx), 32'(mon_e.idx));
        check("rsp_way_oh", 32'(rsp_way_oh), 32'(4'b0001 << mon_e.idx));
        check("rsp_by_rr", 32'(rsp_by_rr), 32'(mon_e.rr));
      end
    end
  end

  // Called one step after a rising edge with the DUT idle.
  task automatic issue(input logic [3:0] s, input logic [3:0] lv, input logic [1:0] idx,
                       input logic rr);
    exp_t e;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    e.idx = idx;
    e.rr  = rr;
    sb.push_back(e);
    issued++;
    req_valid      = 1'b1;
    req_set        = s;
    req_line_valid = lv;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (hs_count < issued && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (hs_count < issued) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=%0d required=%0d", hs_count, issued);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] s, input logic [3:0] lv, input logic [1:0] idx,
                     input logic rr);
    issue(s, lv, idx, rr);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_way_idx", 32'(rsp_way_idx), 32'd0);
    check("rst_way_oh", 32'(rsp_way_oh), 32'h1);
    check("rst_by_rr", 32'(rsp_by_rr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_oh", 32'(rsp_way_oh), 32'h1);

    // Invalid-way pick leaves the pointer alone
    run(4'd3, 4'b1011, 2'd2, 1'b0);
    run(4'd3, Full, 2'd0, 1'b1);
    run(4'd3, Full, 2'd1, 1'b1);

    // Lowest-invalid priority
    run(4'd4, 4'b0000, 2'd0, 1'b0);
    run(4'd4, 4'b1110, 2'd0, 1'b0);
    run(4'd4, 4'b0111, 2'd3, 1'b0);
    run(4'd4, 4'b1101, 2'd1, 1'b0);
    run(4'd4, Full, 2'd0, 1'b1);

    // Round-robin wrap on set 5
    run(4'd5, Full, 2'd0, 1'b1);
    run(4'd5, Full, 2'd1, 1'b1);
    run(4'd5, Full, 2'd2, 1'b1);
    run(4'd5, Full, 2'd3, 1'b1);
    run(4'd5, Full, 2'd0, 1'b1);
    run(4'd5, Full, 2'd1, 1'b1);

    // Set isolation: set 5 at ptr 2
    run(4'd6, Full, 2'd0, 1'b1);
    run(4'd5, Full, 2'd2, 1'b1);

    // Backpressure: outputs hold, inputs ignored
    rsp_ready = 1'b0;
    issue(4'd7, Full, 2'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      req_valid      = 1'b1;
      req_set        = 4'($urandom);
      req_line_valid = 4'($urandom);
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_idx", 32'(rsp_way_idx), 32'd0);
      check("hold_oh", 32'(rsp_way_oh), 32'h1);
      check("hold_by_rr", 32'(rsp_by_rr), 32'd1);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_done();
    run(4'd7, Full, 2'd1, 1'b1);
    run(4'd7, Full, 2'd2, 1'b1);

    // Flush coincident with an advancing handshake on set 1 (ptr 3)
    run(4'd1, Full, 2'd0, 1'b1);
    run(4'd1, Full, 2'd1, 1'b1);
    run(4'd1, Full, 2'd2, 1'b1);
    rsp_ready = 1'b0;
    issue(4'd1, Full, 2'd3, 1'b1);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    wait_done();
    flush = 1'b0;
    run(4'd1, Full, 2'd0, 1'b1);
    run(4'd5, Full, 2'd0, 1'b1);
    run(4'd7, Full, 2'd0, 1'b1);

    // Asynchronous reset in the middle of a pending response
    run(4'd2, Full, 2'd0, 1'b1);
    rsp_ready = 1'b0;
    issue(4'd2, Full, 2'd1, 1'b1);
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd1);
    check("async_rst_idx", 32'(rsp_way_idx), 32'd0);
    check("async_rst_oh", 32'(rsp_way_oh), 32'h1);
    check("async_rst_by_rr", 32'(rsp_by_rr), 32'd0);
    void'(sb.pop_back());
    issued--;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    run(4'd2, Full, 2'd0, 1'b1);
    run(4'd2, Full, 2'd1, 1'b1);
    run(4'd3, Full, 2'd0, 1'b1);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
